// File: rtl/hilo_muldiv_unit_if.sv
// EX-stage request/response bundle between the pipeline and the HI/LO multiply/divide unit.
interface hilo_muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             Start;  // one-cycle op-valid pulse from EX
    logic [2:0]       Op;     // operation select
    logic [WIDTH-1:0] A;      // rs value
    logic [WIDTH-1:0] B;      // rt value
    logic [WIDTH-1:0] HI;     // HI register
    logic [WIDTH-1:0] LO;     // LO register
    logic             Busy;   // long-latency stall request to the hazard unit
    logic             Done;   // HI/LO written by a mult/div this cycle

    // Pipeline side: issues operations, observes results and stall.
    modport master (
        output Start, Op, A, B,
        input  HI, LO, Busy, Done
    );

    // Unit side.
    modport slave (
        input  Start, Op, A, B,
        output HI, LO, Busy, Done
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit with the architectural HI/LO register pair.
// One result bit per cycle: IDLE (cycle 0 latch) -> RUN (WIDTH cycles) -> FIX (sign fixup,
// HI/LO write, Done pulse). Busy drives the hazard unit's long-latency stall.
module hilo_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic                Clock,
    input logic                Reset,
    hilo_muldiv_unit_if.slave  bus
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    localparam logic [2:0] OpMult  = 3'b001;
    localparam logic [2:0] OpMultu = 3'b010;
    localparam logic [2:0] OpDiv   = 3'b011;
    localparam logic [2:0] OpDivu  = 3'b100;
    localparam logic [2:0] OpMthi  = 3'b101;
    localparam logic [2:0] OpMtlo  = 3'b110;

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    // Multiply: {partial product, remaining multiplier}. Divide: {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     a_raw_q, a_raw_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;          // product / quotient sign
    logic                 neg_rem_q, neg_rem_d;  // remainder sign
    logic                 div_zero_q, div_zero_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 is_md;
    logic                 is_div_op;
    logic                 is_signed_op;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_diff;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    // Operation decode and operand magnitudes at issue.
    assign is_md        = (bus.Op == OpMult) || (bus.Op == OpMultu) ||
                          (bus.Op == OpDiv)  || (bus.Op == OpDivu);
    assign is_div_op    = (bus.Op == OpDiv) || (bus.Op == OpDivu);
    assign is_signed_op = (bus.Op == OpMult) || (bus.Op == OpDiv);
    assign abs_a        = (is_signed_op && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign abs_b        = (is_signed_op && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    // Per-iteration datapath: shift-add for multiply, restoring shift-subtract for divide.
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    // When div_ge holds the true difference is below 2^WIDTH, so the low bits suffice.
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;

    // Sign fixup applied in FIX, modulo 2^WIDTH (2^(2*WIDTH) for the product).
    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    // Next-state and datapath update; Start outside IDLE is ignored.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        a_raw_d    = a_raw_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            StIdle: begin
                if (bus.Start) begin
                    case (bus.Op)
                        OpMult, OpMultu, OpDiv, OpDivu: begin
                            state_d    = StRun;
                            cnt_d      = '0;
                            is_div_d   = is_div_op;
                            opnd_d     = is_div_op ? abs_b : abs_a;
                            acc_d      = {{WIDTH{1'b0}}, (is_div_op ? abs_a : abs_b)};
                            a_raw_d    = bus.A;
                            neg_d      = is_signed_op && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                            neg_rem_d  = is_signed_op && bus.A[WIDTH-1];
                            div_zero_d = is_div_op && (bus.B == '0);
                        end
                        OpMthi:  hi_d = bus.A;
                        OpMtlo:  lo_d = bus.A;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                cnt_d = cnt_q + CntW'(1);
                if (is_div_q) begin
                    acc_d = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                                   : {acc_q[2*WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                                     : {1'b0, acc_q[2*WIDTH-1:1]};
                end
                if (cnt_q == CntLast) begin
                    state_d = StFix;
                    cnt_d   = '0;
                end
            end
            StFix: begin
                state_d = StIdle;
                if (is_div_q) begin
                    if (div_zero_q) begin
                        // Divide by zero: quotient all ones, remainder is the raw dividend.
                        lo_d = '1;
                        hi_d = a_raw_q;
                    end else begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register; reset discards any operation in flight and clears HI/LO.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            a_raw_q    <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            a_raw_q    <= a_raw_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    // Busy covers the issue cycle combinationally so a dependent MFHI/MFLO stalls at once.
    assign bus.Busy = (state_q != StIdle) || (bus.Start && is_md);
    assign bus.Done = (state_q == StFix);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: latency/Busy/Done profile, signed and unsigned results,
// divide-by-zero, signed overflow, MTHI/MTLO, ignored Start while busy, async reset mid-run.
module tb_hilo_muldiv_unit;

    localparam int unsigned W = 32;

    localparam logic [2:0] OpMult  = 3'b001;
    localparam logic [2:0] OpMultu = 3'b010;
    localparam logic [2:0] OpDiv   = 3'b011;
    localparam logic [2:0] OpDivu  = 3'b100;
    localparam logic [2:0] OpMthi  = 3'b101;
    localparam logic [2:0] OpMtlo  = 3'b110;

    logic Clock = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;
    int   illegal_starts = 0;
    bit   tb_busy = 1'b0;

    hilo_muldiv_unit_if #(.WIDTH(W)) bus ();

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    // Bench-side tracking of Start issued while an op is known to be in flight.
    always @(posedge Clock) begin
        if (bus.Start && tb_busy) illegal_starts++;
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Issue one mult/div and check Busy/Done every cycle through cycle W+2, then HI/LO.
    // With inject set, an MTLO is driven at cycle 5 and must be ignored.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo, input bit inject);
        @(posedge Clock); #1;
        bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
        @(negedge Clock);
        chk($sformatf("%s busy c0", tag), W'(bus.Busy), W'(1));
        chk($sformatf("%s done c0", tag), W'(bus.Done), W'(0));
        @(posedge Clock); #1;
        bus.Start = 1'b0; bus.Op = 3'b000; bus.A = '0; bus.B = '0;
        tb_busy = 1'b1;
        for (int c = 1; c <= W + 1; c++) begin
            if (inject && c == 5) begin
                bus.Start = 1'b1; bus.Op = OpMtlo; bus.A = 32'hDEADBEEF;
            end
            @(negedge Clock);
            chk($sformatf("%s busy c%0d", tag, c), W'(bus.Busy), W'(1));
            chk($sformatf("%s done c%0d", tag, c), W'(bus.Done), W'(c == W + 1));
            @(posedge Clock); #1;
            bus.Start = 1'b0; bus.Op = 3'b000; bus.A = '0;
        end
        tb_busy = 1'b0;
        @(negedge Clock);
        chk($sformatf("%s busy end", tag), W'(bus.Busy), W'(0));
        chk($sformatf("%s done end", tag), W'(bus.Done), W'(0));
        chk($sformatf("%s HI", tag), bus.HI, exp_hi);
        chk($sformatf("%s LO", tag), bus.LO, exp_lo);
    endtask

    initial begin
        Reset = 1'b0;
        bus.Start = 1'b0; bus.Op = 3'b000; bus.A = '0; bus.B = '0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        chk("reset HI", bus.HI, '0);
        chk("reset LO", bus.LO, '0);
        chk("reset busy", W'(bus.Busy), W'(0));
        chk("reset done", W'(bus.Done), W'(0));
        @(posedge Clock); #1;
        Reset = 1'b1;

        // MTHI / MTLO while idle: one-cycle write, no Busy, no Done.
        bus.Start = 1'b1; bus.Op = OpMthi; bus.A = 32'hCAFE0001;
        @(negedge Clock);
        chk("mthi busy", W'(bus.Busy), W'(0));
        chk("mthi HI before", bus.HI, '0);
        @(posedge Clock); #1;
        bus.Op = OpMtlo; bus.A = 32'h0BADF00D;
        @(negedge Clock);
        chk("mthi HI after", bus.HI, 32'hCAFE0001);
        chk("mtlo busy", W'(bus.Busy), W'(0));
        chk("mthi done", W'(bus.Done), W'(0));
        @(posedge Clock); #1;
        bus.Start = 1'b0; bus.Op = 3'b000; bus.A = '0;
        @(negedge Clock);
        chk("mtlo LO after", bus.LO, 32'h0BADF00D);
        chk("mtlo HI hold", bus.HI, 32'hCAFE0001);

        // Undefined opcodes are no-ops.
        @(posedge Clock); #1;
        bus.Start = 1'b1; bus.Op = 3'b111; bus.A = 32'h11111111; bus.B = 32'h2;
        @(negedge Clock);
        chk("op111 busy", W'(bus.Busy), W'(0));
        @(posedge Clock); #1;
        bus.Op = 3'b000;
        @(negedge Clock);
        chk("op000 busy", W'(bus.Busy), W'(0));
        @(posedge Clock); #1;
        bus.Start = 1'b0; bus.A = '0; bus.B = '0;
        @(negedge Clock);
        chk("noop HI", bus.HI, 32'hCAFE0001);
        chk("noop LO", bus.LO, 32'h0BADF00D);
        chk("noop done", W'(bus.Done), W'(0));

        run_op("mult -3*5",   OpMult,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 0);
        run_op("multu max",   OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
        run_op("div -7/2",    OpDiv,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_op("divu",        OpDivu,  32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 0);
        run_op("div by 0",    OpDiv,   32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 0);
        run_op("div ovf",     OpDiv,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
        run_op("mult 6*-7",   OpMult,  32'd6,        32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFD6, 0);
        run_op("div 100/7 +mtlo", OpDiv, 32'd100,    32'd7,        32'h00000002, 32'h0000000E, 1);
        chk("ignored starts seen", illegal_starts, 1);

        // Asynchronous reset at cycle 10 of a MULT.
        @(posedge Clock); #1;
        bus.Start = 1'b1; bus.Op = OpMult; bus.A = 32'd7; bus.B = 32'd9;
        @(posedge Clock); #1;
        bus.Start = 1'b0; bus.Op = 3'b000; bus.A = '0; bus.B = '0;
        repeat (9) @(posedge Clock);
        #3;
        chk("pre-reset busy", W'(bus.Busy), W'(1));
        Reset = 1'b0;
        #1;
        chk("async reset busy", W'(bus.Busy), W'(0));
        chk("async reset HI", bus.HI, '0);
        chk("async reset LO", bus.LO, '0);
        chk("async reset done", W'(bus.Done), W'(0));
        @(posedge Clock); #1;
        Reset = 1'b1;
        for (int c = 0; c < W + 8; c++) begin
            @(negedge Clock);
            chk($sformatf("post-reset done %0d", c), W'(bus.Done), W'(0));
            chk($sformatf("post-reset busy %0d", c), W'(bus.Busy), W'(0));
        end
        chk("post-reset HI", bus.HI, '0);
        chk("post-reset LO", bus.LO, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
